// File: rtl/lfsr_sng.sv
// lfsr_sng: binary -> unipolar stochastic bitstream, one full LFSR period per start.
// Ports: clk, rst (sync, high); in start/value/hold; out bit_out/bit_valid/busy/done.
module lfsr_sng #(
  parameter int WIDTH = 8,
  parameter int SEED  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic             hold,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int LEN = (1 << WIDTH) - 1;

  // Maximal-length taps, bit t-1 set for 1-based tap t.
  function automatic logic [15:0] tap_mask(input int w);
    case (w)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  localparam logic [WIDTH-1:0] MASK   = WIDTH'(tap_mask(WIDTH));
  localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] LAST   = WIDTH'(LEN - 1);

  if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
    $error("lfsr_sng: WIDTH must be within 4..16");
  end
  if (SEED <= 0 || SEED > LEN) begin : g_bad_seed
    $error("lfsr_sng: SEED must be nonzero and below 2^WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] lfsr, lfsr_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] cnt, cnt_d;
  logic             fb;
  logic [WIDTH-1:0] lfsr_step;

  assign fb        = ^(lfsr & MASK);
  assign lfsr_step = {lfsr[WIDTH-2:0], fb};

  always_comb begin
    state_d   = state;
    lfsr_d    = lfsr;
    value_d   = value_q;
    cnt_d     = cnt;
    bit_out   = 1'b0;
    bit_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          value_d = value;
          lfsr_d  = SEED_V;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        bit_out   = (lfsr <= value_q);
        bit_valid = ~hold;
        if (!hold) begin
          lfsr_d = lfsr_step;
          // cnt saturates at LAST so it never wraps.
          if (cnt == LAST) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lfsr    <= SEED_V;
      value_q <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_d;
      lfsr    <= lfsr_d;
      value_q <= value_d;
      cnt     <= cnt_d;
    end
  end

endmodule
